// File: rtl/slave_module.sv
// slave_module
//   Memory-backed responder for the main_int req/ack/resp protocol. It services one
//   transaction at a time. Each transaction is acknowledged ACK_LAT cycles after the
//   request is sampled. A write is committed to a local 2^ADDR_W x 32 word array on
//   the acknowledge edge. A read returns data with a resp_o pulse RD_LAT cycles after
//   its acknowledge.
//
//   Optional feature macro: SLAVE_ADDR_CHECK_EN
//     If defined, addresses with addr_i[30:ADDR_W] != 0 are out of range:
//       - writes are dropped;
//       - reads return 32'hDEAD_BEEF;
//       - err_o flags the qualifying ack_o (write) or resp_o (read).
//     If undefined, the upper address bits alias and err_o is tied to 0.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_n_i  : synchronous active-low reset (array contents are retained)
//   req_i    : request, held by the master until ack_o (write) / resp_o (read)
//   addr_i   : word address, bits [ADDR_W-1:0] index the array
//   cmd_i    : 1 = write, 0 = read
//   wdata_i  : write data
//   ack_o    : one-cycle acknowledge pulse
//   resp_o   : one-cycle read-response pulse
//   rdata_o  : read data, valid with resp_o and held until the next response
//   err_o    : address-range error, qualified by ack_o (write) / resp_o (read)
module slave_module #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned ACK_LAT = 1,
   parameter int unsigned RD_LAT  = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_i,
   input  logic [30:0] addr_i,
   input  logic        cmd_i,
   input  logic [31:0] wdata_i,
   output logic        ack_o,
   output logic        resp_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned Depth = 1 << ADDR_W;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAck  = 2'd1;
   localparam logic [1:0] StRd   = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              cmd_q, cmd_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       data_q, data_d;    // read data captured on the ack edge
   logic [31:0]       rdata_q, rdata_d;  // last delivered response, held between reads
   logic              oor_q, oor_d;
   logic              addr_oor;
   logic              mem_we;

   logic [31:0] mem [Depth];

`ifdef SLAVE_ADDR_CHECK_EN
   assign addr_oor = |addr_i[30:ADDR_W];
`else
   logic unused_addr_hi;
   assign addr_oor       = 1'b0;
   assign unused_addr_hi = ^addr_i[30:ADDR_W];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      oor_d   = oor_q;
      mem_we  = 1'b0;
      ack_o   = 1'b0;
      resp_o  = 1'b0;

      case (state_q)
         StIdle: begin
            if (req_i) begin
               addr_d  = addr_i[ADDR_W-1:0];
               cmd_d   = cmd_i;
               wdata_d = wdata_i;
               oor_d   = addr_oor;
               cnt_d   = 4'(ACK_LAT - 1);
               state_d = StAck;
            end
         end
         StAck: begin
            if (cnt_q == 4'd0) begin
               ack_o = 1'b1;
               if (cmd_q) begin
                  mem_we  = ~oor_q;
                  state_d = StDone;
               end else begin
                  data_d  = oor_q ? 32'hDEAD_BEEF : mem[addr_q];
                  cnt_d   = 4'(RD_LAT - 1);
                  state_d = StRd;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRd: begin
            if (cnt_q == 4'd0) begin
               resp_o  = 1'b1;
               rdata_d = data_q;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            // Wait for the master's registered req drop so it is not seen as a new request.
            if (!req_i) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // Data appears in the resp cycle itself, then stays on the held copy.
   assign rdata_o = resp_o ? data_q : rdata_q;

`ifdef SLAVE_ADDR_CHECK_EN
   assign err_o = oor_q & ((ack_o & cmd_q) | resp_o);
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         cmd_q   <= 1'b0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
         rdata_q <= 32'd0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         oor_q   <= oor_d;
      end
   end

   // Array is not reset; a reset landing on the ack edge discards the write.
   always_ff @(posedge clk_i) begin
      if (mem_we && rst_n_i) begin
         mem[addr_q] <= wdata_q;
      end
   end

endmodule

// File: doc/slave_module.md
# slave_module

Memory-backed responder for the main_int req/ack/resp protocol: the slave-side counterpart of the two-way master router, instantiated once per slave port (s0, s1). It accepts one transaction at a time, acknowledges it after a fixed latency, commits writes to a local word array, and returns read data with a separate `resp` pulse after a second fixed latency.

## Interface
- `ADDR_W`, 8: word-index width; array depth is 2^ADDR_W words of 32 bits.
- `ACK_LAT`, 1: cycles from the `req_i` sample to the `ack_o` pulse; legal range 1..15.
- `RD_LAT`, 2: cycles from the read `ack_o` pulse to the `resp_o` pulse; legal range 1..15.

- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `req_i`  in  1  request; held high by the master until `ack_o` (write) or `resp_o` (read).
- `addr_i`  in  31  word address; bits [ADDR_W-1:0] index the array.
- `cmd_i`  in  1  1 = write, 0 = read.
- `wdata_i`  in  32  write data.
- `ack_o`  out  1  one-cycle acknowledge pulse.
- `resp_o`  out  1  one-cycle read-response pulse (reads only).
- `rdata_o`  out  32  read data; valid while `resp_o` = 1, and held until the next read response.
- `err_o`  out  1  address-range error flag, qualified by `ack_o` (writes) or `resp_o` (reads); constant 0 unless the configuration macro is defined.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ACK: count ACK_LAT.
  - RD: count RD_LAT.
  - DONE: wait for `req_i` to drop.
- IDLE, `req_i` = 1:
  - Register `addr_i`, `cmd_i` and `wdata_i`.
  - Load the counter with ACK_LAT-1 and go to ACK.
  - Later changes on the master inputs are ignored until the FSM returns to IDLE.
- ACK: decrement the counter each cycle. When it reaches 0:
  - Assert `ack_o` for one cycle.
  - Write: commit the registered `wdata` to `mem[addr[ADDR_W-1:0]]` on the same edge, then go to DONE.
  - Read: capture `mem[addr]` into a data register, load the counter with RD_LAT-1, then go to RD.
- RD: when the counter reaches 0, assert `resp_o` for one cycle, drive `rdata_o` from the data register, then go to DONE.
- DONE:
  - `ack_o` and `resp_o` are 0.
  - Go to IDLE on the first cycle `req_i` = 0.
  - This stops the master's registered `req` drop (one cycle after `ack`/`resp`) from being taken as a new request.
- Boundary conditions:
  - `req_i` dropping early in ACK or RD is a protocol violation. The transaction still completes in full and DONE then exits at once.
  - `req_i` held high forever: the slave stays in DONE; no second `ack_o` or `resp_o`.
  - Address bits above ADDR_W are ignored (aliasing), unless the macro below is defined.
- Array contents are not reset; they are retained across `rst_n_i`.

## Timing
- Reset (synchronous, mid-transaction included):
  - `ack_o` = 0, `resp_o` = 0, `rdata_o` = 0, `err_o` = 0, state = IDLE.
  - Any in-flight write that has not yet been acked is discarded.
- Let the rising edge that samples `req_i` = 1 be edge E.
  - `ack_o` is high for the cycle following edge E+ACK_LAT-1. With ACK_LAT = 1, `ack_o` is high in the cycle immediately after the sample.
  - Read: `resp_o` is high exactly RD_LAT cycles after the `ack_o` cycle.
  - Write: the new data is readable by any request sampled after the `ack_o` cycle.
- Throughput: at least 1 DONE cycle plus 1 IDLE sample between transactions.
  - Minimum write period: ACK_LAT+2 cycles.
  - Minimum read period: ACK_LAT+RD_LAT+2 cycles.
- `ack_o` and `resp_o` are never high in the same cycle.

## Configuration
- `SLAVE_ADDR_CHECK_EN` defined:
  - A transaction with `addr_i[30:ADDR_W]` ≠ 0 is out of range.
  - Out-of-range write: the array is not written; `err_o` = 1 together with `ack_o`.
  - Out-of-range read: `rdata_o` = 32'hDEAD_BEEF and `err_o` = 1 together with `resp_o`.
  - Handshake timing is unchanged.
- `SLAVE_ADDR_CHECK_EN` undefined: `err_o` is tied to 0 and upper address bits alias.

## Test plan
- Write then read (ACK_LAT = 1, RD_LAT = 2):
  - Write 32'hA5A5_0001 to address 5 -> `ack_o` is high 1 cycle after the `req_i` sample.
  - Read address 5 -> `ack_o` as for the write, then `resp_o` 2 cycles later with `rdata_o` = 32'hA5A5_0001.
- Latency sweep ACK_LAT = 3, RD_LAT = 4, read -> `ack_o` at cycle 3 and `resp_o` at cycle 7 after the sample; exactly one pulse of each.
- `req_i` held high for 10 cycles after `resp_o` -> no further `ack_o`/`resp_o`. Drop `req_i` -> IDLE after 1 cycle; the next request is serviced normally.
- Reset asserted in the cycle before a write `ack_o` -> no ack is seen, all outputs are 0, and a later read of that address returns the old contents.
- Back-to-back writes to addresses 0..3 through the master router -> each completes in ACK_LAT+2 cycles, and read-back returns the written values in order.
- With `SLAVE_ADDR_CHECK_EN`:
  - Write to address 31'h100 (ADDR_W = 8) -> `err_o` = 1 with `ack_o`, and address 0 is unchanged.
  - Read 31'h100 -> 32'hDEAD_BEEF with `err_o` = 1.
